// File: rtl/sssp_pkg.sv
// Shared SSSP accelerator types: minimal CCI-P channel 1 view, the update bin writer
// FSM states and the status line layout.
package sssp_pkg;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [15:0]  t_ccip_mdata;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'h0,
        eCL_LEN_2 = 2'h1,
        eCL_LEN_4 = 2'h3
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h1,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h6
    } t_ccip_c1_rsp;

    typedef struct packed {
        logic [5:0]   rsvd1;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd0;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd2;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StStream  = 4'd1,
        StDrain   = 4'd2,
        StStatus  = 4'd3,
        StWaitRsp = 4'd4,
        StDone    = 4'd5
    } t_ubw_state;

    localparam logic [63:0] StatusMagic    = 64'h1;
    localparam int unsigned StatusLinesLsb = 64;
    localparam int unsigned StatusWordLsb  = 96;
    localparam int unsigned StatusOvfBit   = 128;

    function automatic t_ccip_c1_ReqMemHdr wr_hdr(input t_ccip_clAddr addr);
        t_ccip_c1_ReqMemHdr h;
        h          = '0;
        h.vc_sel   = eVC_VA;
        h.sop      = 1'b1;
        h.cl_len   = eCL_LEN_1;
        h.req_type = eREQ_WRLINE_I;
        h.address  = addr;
        h.mdata    = '0;
        return h;
    endfunction

    function automatic t_ccip_clData status_line(input logic [31:0] lines,
                                                 input logic [31:0] word,
                                                 input logic        ovf);
        t_ccip_clData l;
        l                          = '0;
        l[63:0]                    = StatusMagic;
        l[StatusLinesLsb +: 32]    = lines;
        l[StatusWordLsb +: 32]     = word;
        l[StatusOvfBit]            = ovf;
        return l;
    endfunction

endpackage

// File: rtl/ubw_fifo.sv
// Synchronous show-ahead FIFO: pop_data is the head entry whenever empty is low.
// A push while full is accepted only when a pop happens on the same cycle.
module ubw_fifo #(
    parameter int unsigned WIDTH = 512,
    parameter int unsigned DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = mem[rd_ptr];
        count    = count_q;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/update_bin_writer.sv
// Streams sssp update words into consecutive host cache lines over CCI-P channel 1, then
// fences on all write responses and writes a single status line.
module update_bin_writer
    import sssp_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 64,
    parameter int unsigned AFULL_THRESH = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  t_ccip_clAddr   bin_addr,
    input  t_ccip_clAddr   status_addr,
    input  logic [31:0]    status_word,
    input  logic [511:0]   in_data,
    input  logic           in_valid,
    input  logic           flush,
    input  logic           c1TxAlmFull,
    input  t_if_ccip_c1_Rx c1rx,
    output t_if_ccip_c1_Tx c1tx,
    output logic           almost_full,
    output logic           done,
    output logic [31:0]    lines_written,
    output logic           overflow,
    output logic [3:0]     state_out
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    t_ubw_state   state;
    t_ccip_clAddr bin_addr_q;
    t_ccip_clAddr status_addr_q;
    logic [31:0]  status_word_q;
    logic [31:0]  rsp_cnt;

    logic [511:0] fifo_data;
    logic [CW-1:0] fifo_count;
    logic         fifo_full;
    logic         fifo_empty;
    logic         in_run;
    logic         accept;
    logic         fifo_pop;
    logic         drained;

    // Response headers carry nothing useful: every write is a single line.
    logic unused_rsp_hdr;
    assign unused_rsp_hdr = ^c1rx.hdr;

    assign state_out = state;

    always_comb begin
        in_run   = (state == StStream) || (state == StDrain);
        accept   = in_valid && in_run;
        fifo_pop = in_run && !fifo_empty && !c1TxAlmFull;
        // Fence: nothing buffered, nothing in the output register, every write acknowledged.
        drained  = (state == StDrain) && fifo_empty && !in_valid && !c1tx.valid &&
                   (rsp_cnt == lines_written);
    end

    ubw_fifo #(
        .WIDTH (512),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= StIdle;
            c1tx          <= '0;
            done          <= 1'b0;
            lines_written <= '0;
            overflow      <= 1'b0;
            almost_full   <= 1'b0;
            rsp_cnt       <= '0;
            bin_addr_q    <= '0;
            status_addr_q <= '0;
            status_word_q <= '0;
        end else begin
            c1tx.valid  <= 1'b0;
            done        <= 1'b0;
            almost_full <= (32'(fifo_count) >= AFULL_THRESH);

            if (c1rx.rspValid && (state != StIdle)) begin
                rsp_cnt <= rsp_cnt + 32'd1;
            end
            if (accept && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
            if (fifo_pop) begin
                c1tx.hdr      <= wr_hdr(bin_addr_q + {10'b0, lines_written});
                c1tx.data     <= fifo_data;
                c1tx.valid    <= 1'b1;
                lines_written <= lines_written + 32'd1;
            end

            case (state)
                StIdle: begin
                    if (start) begin
                        state         <= StStream;
                        bin_addr_q    <= bin_addr;
                        status_addr_q <= status_addr;
                        lines_written <= '0;
                        rsp_cnt       <= '0;
                        overflow      <= 1'b0;
                    end
                end
                StStream: begin
                    if (flush) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (drained) begin
                        state         <= StStatus;
                        status_word_q <= status_word;
                    end
                end
                StStatus: begin
                    if (!c1TxAlmFull) begin
                        c1tx.hdr   <= wr_hdr(status_addr_q);
                        c1tx.data  <= status_line(lines_written, status_word_q, overflow);
                        c1tx.valid <= 1'b1;
                        state      <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    if (c1rx.rspValid) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_update_bin_writer.sv
// Randomised bench for update_bin_writer: captures every channel 1 write, answers with
// delayed responses and compares against an expected line list built from the words sent.
module tb_update_bin_writer;
    import sssp_pkg::*;

    localparam int Depth = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    t_ccip_clAddr   bin_addr;
    t_ccip_clAddr   status_addr;
    logic [31:0]    status_word;
    logic [511:0]   in_data;
    logic           in_valid;
    logic           flush;
    logic           c1TxAlmFull;
    t_if_ccip_c1_Rx c1rx;
    t_if_ccip_c1_Tx c1tx;
    logic           almost_full;
    logic           done;
    logic [31:0]    lines_written;
    logic           overflow;
    logic [3:0]     state_out;

    update_bin_writer #(
        .FIFO_DEPTH   (64),
        .AFULL_THRESH (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .bin_addr      (bin_addr),
        .status_addr   (status_addr),
        .status_word   (status_word),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .flush         (flush),
        .c1TxAlmFull   (c1TxAlmFull),
        .c1rx          (c1rx),
        .c1tx          (c1tx),
        .almost_full   (almost_full),
        .done          (done),
        .lines_written (lines_written),
        .overflow      (overflow),
        .state_out     (state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [41:0]  addr;
        logic [511:0] data;
        logic [25:0]  hdr_bits;   // {req_type, vc_sel, cl_len, sop, mdata}
    } wr_t;

    int   total = 0;
    int   bad = 0;
    int   cycle_cnt = 0;
    wr_t  cap[$];
    int   rsp_q[$];
    int   last_due = 0;
    int   stale_n = 0;
    int   done_cnt = 0;
    int   first_valid_cyc = 0;
    bit   afull_seen = 0;
    bit   prev_alm = 0;
    int   alm_mode = 0;
    bit   alm_force = 0;
    bit   abort = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_word();
        logic [511:0] w;
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    initial forever begin
        @(posedge clk);
        cycle_cnt++;
    end

    // Channel 1 almost-full source.
    initial forever begin
        @(posedge clk);
        #1;
        case (alm_mode)
            1:       c1TxAlmFull = ($urandom_range(0, 3) == 0);
            2:       c1TxAlmFull = alm_force;
            default: c1TxAlmFull = 1'b0;
        endcase
    end

    // Response source: one response per cycle, each a random few cycles after its write.
    initial forever begin
        @(posedge clk);
        #1;
        if (stale_n > 0) begin
            c1rx.rspValid = 1'b1;
            stale_n--;
        end else if (rsp_q.size() > 0 && rsp_q[0] <= cycle_cnt) begin
            c1rx.rspValid = 1'b1;
            void'(rsp_q.pop_front());
        end else begin
            c1rx.rspValid = 1'b0;
        end
    end

    // Write monitor.
    initial forever begin
        wr_t w;
        int  due;
        @(negedge clk);
        if (c1tx.valid) begin
            check_eq("no_issue_while_almfull", 512'(prev_alm), 512'(0));
            w.addr     = c1tx.hdr.address;
            w.data     = c1tx.data;
            w.hdr_bits = {c1tx.hdr.req_type, c1tx.hdr.vc_sel, c1tx.hdr.cl_len, c1tx.hdr.sop,
                          c1tx.hdr.mdata};
            if (cap.size() == 0) first_valid_cyc = cycle_cnt;
            cap.push_back(w);
            due = cycle_cnt + int'($urandom_range(1, 6));
            if (due <= last_due) due = last_due + 1;
            rsp_q.push_back(due);
            last_due = due;
        end
        if (done) done_cnt++;
        if (almost_full) afull_seen = 1;
        prev_alm = c1TxAlmFull;
    end

    task automatic run_case(input int n, input logic [41:0] base, input bit honour,
                            input bit flush_last, input int gap_max, input bit check_lat);
        logic [511:0] exp_q[$];
        logic [511:0] w;
        logic [511:0] exp_status;
        logic [41:0]  exp_addr;
        int           first_drive = 0;
        int           guard;
        bit           exp_ovf;
        cap.delete();
        done_cnt    = 0;
        bin_addr    = base;
        status_addr = {$urandom, $urandom} & 42'h3FF_FFFF_FFFF;
        status_word = $urandom;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            while (honour && almost_full && guard < 500) begin
                tick();
                guard++;
            end
            if (guard >= 500) check_eq("afull_wait_timeout", 1, 0);
            w        = rand_word();
            in_data  = w;
            in_valid = 1'b1;
            if (honour || exp_q.size() < Depth) exp_q.push_back(w);
            if (flush_last && i == n - 1) flush = 1'b1;
            if (i == 0) first_drive = cycle_cnt;
            tick();
            in_valid = 1'b0;
            flush    = 1'b0;
            repeat ($urandom_range(0, gap_max)) tick();
        end
        if (!honour) alm_force = 1'b0;
        if (!(flush_last && n > 0)) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        for (int k = 0; k < 4000 && done_cnt == 0; k++) tick();
        repeat (4) tick();
        exp_ovf = !honour && (n > Depth);
        check_eq("done_pulses", 512'(done_cnt), 512'(1));
        check_eq("write_count", 512'(cap.size()), 512'(exp_q.size() + 1));
        if (cap.size() == exp_q.size() + 1) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                exp_addr = base + 42'(i);
                check_eq($sformatf("data_addr[%0d]", i), 512'(cap[i].addr), 512'(exp_addr));
                check_eq($sformatf("data_line[%0d]", i), cap[i].data, exp_q[i]);
                check_eq($sformatf("data_hdr[%0d]", i), 512'(cap[i].hdr_bits),
                         512'({4'h0, 2'h0, 2'h0, 1'b1, 16'h0}));
            end
            exp_status = 512'(64'h1) | (512'(exp_q.size()) << 64) |
                         (512'(status_word) << 96) | (512'(exp_ovf) << 128);
            check_eq("status_addr", 512'(cap[exp_q.size()].addr), 512'(status_addr));
            check_eq("status_line", cap[exp_q.size()].data, exp_status);
            check_eq("status_hdr", 512'(cap[exp_q.size()].hdr_bits),
                     512'({4'h0, 2'h0, 2'h0, 1'b1, 16'h0}));
        end
        check_eq("lines_written", 512'(lines_written), 512'(exp_q.size()));
        check_eq("overflow", 512'(overflow), 512'(exp_ovf));
        check_eq("state_idle_after_done", 512'(state_out), 512'(0));
        if (check_lat && n > 0) begin
            check_eq("first_issue_latency", 512'(first_valid_cyc - first_drive), 512'(2));
        end
    endtask

    initial begin
        int n_before;
        reset       = 1'b1;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        flush       = 1'b0;
        bin_addr    = '0;
        status_addr = '0;
        status_word = '0;
        c1TxAlmFull = 1'b0;
        c1rx        = '0;
        repeat (3) tick();
        check_eq("rst_valid", 512'(c1tx.valid), 512'(0));
        check_eq("rst_done", 512'(done), 512'(0));
        check_eq("rst_lines", 512'(lines_written), 512'(0));
        check_eq("rst_overflow", 512'(overflow), 512'(0));
        check_eq("rst_afull", 512'(almost_full), 512'(0));
        check_eq("rst_state", 512'(state_out), 512'(0));
        reset = 1'b0;
        tick();

        // Five back-to-back words, open channel.
        alm_mode = 0;
        run_case(5, {$urandom, $urandom} & 42'h3FF_FFFF_FFFF, 1, 0, 0, 1);

        // Channel held almost-full for 20 cycles while a 10-word burst arrives.
        afull_seen = 0;
        alm_mode   = 2;
        alm_force  = 1'b1;
        fork
            begin
                repeat (20) tick();
                alm_force = 1'b0;
            end
            run_case(10, {$urandom, $urandom} & 42'h3FF_FFFF_FFFF, 1, 0, 0, 0);
        join
        check_eq("afull_seen", 512'(afull_seen), 512'(1));

        // Empty run, then address wrap with flush on the last word.
        alm_mode = 0;
        run_case(0, 42'h123, 1, 0, 0, 0);
        run_case(4, 42'h3FF_FFFF_FFFE, 1, 1, 0, 0);

        // 65 words into a stalled channel: one word is lost.
        alm_mode  = 2;
        alm_force = 1'b1;
        run_case(65, {$urandom, $urandom} & 42'h3FF_FFFF_FFFF, 0, 0, 0, 0);
        alm_mode = 0;

        // Reset mid-run, then stale responses while idle, then a clean run.
        cap.delete();
        abort    = 0;
        bin_addr = 42'h100;
        start    = 1'b1;
        tick();
        start = 1'b0;
        fork
            begin
                for (int i = 0; i < 8 && !abort; i++) begin
                    in_data  = rand_word();
                    in_valid = 1'b1;
                    tick();
                end
                in_valid = 1'b0;
            end
            begin
                int g = 0;
                while (cap.size() < 3 && g < 100) begin
                    tick();
                    g++;
                end
                if (g >= 100) check_eq("reset_wait_timeout", 1, 0);
                reset = 1'b1;
                abort = 1;
                tick();
                check_eq("reset_mid_state", 512'(state_out), 512'(0));
                check_eq("reset_mid_valid", 512'(c1tx.valid), 512'(0));
                check_eq("reset_mid_lines", 512'(lines_written), 512'(0));
                reset = 1'b0;
            end
        join
        in_valid = 1'b0;
        n_before = cap.size();
        repeat (5) tick();
        check_eq("no_tx_after_reset", 512'(cap.size()), 512'(n_before));
        stale_n = 3;
        repeat (20) tick();
        check_eq("idle_after_stale_rsp", 512'(state_out), 512'(0));
        run_case(6, 42'h200, 1, 0, 1, 0);

        // Random runs under a flickering almost-full.
        alm_mode = 1;
        for (int r = 0; r < 6; r++) begin
            run_case(int'($urandom_range(0, 24)), {$urandom, $urandom} & 42'h3FF_FFFF_FFFF, 1,
                     bit'($urandom_range(0, 1)), 2, 0);
        end
        alm_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
